fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Program-counter and fetch sequencer for the 9-bit single-cycle core. It sits directly upstream of the instruction ROM and control decoder: ProgCtr addresses the ROM, and the decoder's BranchEn plus the ALU's Taken flag come back to select the next PC. A Start/Done handshake runs each program from a host-supplied start address until a halt is decoded.

Parameters:
PC_W, 10, program counter width in bits (ROM depth 2^PC_W)
CNT_W, 16, width of retired-instruction counter (optional feature only)

Ports:
Clk  input  1  core clock, all state updates on rising edge
Reset_n  input  1  one clock; reset is synchronous and active-low
Start  input  1  host request; level-held while host loads start address
StartAddr  input  PC_W  first instruction address of program
BranchEn  input  1  from control decoder: current instruction is a branch
Taken  input  1  from ALU flags: branch condition true
Target  input  PC_W  absolute branch target (from branch LUT)
Halt  input  1  from control decoder: current instruction is halt
ProgCtr  output  PC_W  current instruction address to ROM
Running  output  1  high while in RUN
Done  output  1  high while in DONE
InstrCount  output  CNT_W  retired-instruction count (see Optional Feature)

Behaviour:
- Reset (Reset_n=0 at rising edge): state=IDLE, ProgCtr=0, Running=0, Done=0, InstrCount=0. Takes effect from any state, mid-program included; overrides all other inputs.
- States: IDLE, LOAD, RUN, DONE. Running and Done are registered decodes of state.
- IDLE: ProgCtr holds. Start=1 -> LOAD, ProgCtr<=StartAddr.
- LOAD: ProgCtr<=StartAddr every cycle while Start=1, so late StartAddr changes are tracked. Start=0 -> RUN, with ProgCtr holding the last loaded StartAddr. First instruction executes in the first RUN cycle.
- RUN, per cycle, priority highest first:
  1. Start=1 -> LOAD, ProgCtr<=StartAddr. This is an abort/restart.
  2. Halt=1 -> DONE, ProgCtr holds. The halt instruction counts as retired.
  3. BranchEn=1 and Taken=1 -> ProgCtr<=Target. Target==ProgCtr is legal and spins in place.
  4. Otherwise ProgCtr<=ProgCtr+1.
- BranchEn=1 with Taken=0 falls through to +1.
- Wrap: in RUN at ProgCtr = 2^PC_W-1 with no taken branch -> DONE, ProgCtr holds; no silent wrap to 0. A taken branch at the last address is followed normally.
- DONE: ProgCtr holds, Done=1. Start=1 -> LOAD. BranchEn, Taken and Halt are ignored.
- Next-PC latency: one cycle; ProgCtr is registered with no combinational path from inputs to ProgCtr.
- Inputs other than Start, StartAddr and Reset_n are ignored outside RUN.

Optional Feature:
- Macro: FETCH_INSTR_COUNT_EN.
- Defined: InstrCount increments by 1 for each RUN cycle, i.e. each retired instruction, including the halting one and the final wrap cycle.
  - Saturates at 2^CNT_W-1.
  - Clears to 0 on entry to LOAD and on reset.
  - Holds in IDLE and DONE.
- Undefined: no counter register; InstrCount is tied to 0.

Test Plan:
- Reset_n=0 mid-RUN at ProgCtr=37 -> next edge ProgCtr=0, Running=0, Done=0, state IDLE; Start ignored during that edge.
- Start=1 for 3 cycles with StartAddr=5, then 9, then Start=0 -> ProgCtr=9 in LOAD; RUN follows with ProgCtr sequence 9,10,11.
- In RUN at ProgCtr=12: BranchEn=1, Taken=1, Target=3 -> ProgCtr=3. At 12 with BranchEn=1, Taken=0 -> ProgCtr=13.
- Halt=1 together with BranchEn=1, Taken=1 at ProgCtr=20 -> DONE, ProgCtr=20, Done=1. Start=1 then loads StartAddr and Done falls next cycle.
- PC_W=4, run from StartAddr=14 with no branches -> ProgCtr 14, 15, then DONE with ProgCtr=15. Never reaches 0.
- With FETCH_INSTR_COUNT_EN: StartAddr=0, straight-line code, Halt at address 6 -> InstrCount=7 in DONE. A restart via Start clears it to 0. Without the macro, InstrCount=0 throughout.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch sequencer bus: host start request, decoder/ALU branch feedback,
// and the PC/status outputs towards ROM and host.
interface fetch_unit_if #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
);
    logic             Start;
    logic [PC_W-1:0]  StartAddr;
    logic             BranchEn;
    logic             Taken;
    logic [PC_W-1:0]  Target;
    logic             Halt;
    logic [PC_W-1:0]  ProgCtr;
    logic             Running;
    logic             Done;
    logic [CNT_W-1:0] InstrCount;

    modport master (
        output Start, StartAddr, BranchEn, Taken, Target, Halt,
        input  ProgCtr, Running, Done, InstrCount
    );

    modport slave (
        input  Start, StartAddr, BranchEn, Taken, Target, Halt,
        output ProgCtr, Running, Done, InstrCount
    );
endinterface

// File: rtl/fetch_unit.sv
// Program counter / fetch sequencer (IDLE -> LOAD -> RUN -> DONE).
// Optional retired-instruction counter enabled by macro FETCH_INSTR_COUNT_EN.
module fetch_unit #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
) (
    input  logic         Clk,
    input  logic         Reset_n,
    fetch_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [PC_W-1:0] PC_LAST = {PC_W{1'b1}};
    localparam logic [PC_W-1:0] PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            running_q, running_d;
    logic            done_q, done_d;

    // Next-state and next-PC selection; Start always wins, then Halt, then branch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    state_d = LOAD;
                    pc_d    = bus.StartAddr;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (bus.Start) begin
                    pc_d = bus.StartAddr;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.Start) begin
                    state_d = LOAD;
                    pc_d    = bus.StartAddr;
                end else if (bus.Halt) begin
                    state_d = DONE;
                end else if (bus.BranchEn && bus.Taken) begin
                    pc_d = bus.Target;
                end else if (pc_q == PC_LAST) begin
                    // Falling off the end of ROM stops the program instead of wrapping.
                    state_d = DONE;
                end else begin
                    pc_d = pc_q + PC_ONE;
                end
            end
            DONE: begin
                if (bus.Start) begin
                    state_d = LOAD;
                    pc_d    = bus.StartAddr;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = {PC_W{1'b0}};
            end
        endcase
        running_d = (state_d == RUN);
        done_d    = (state_d == DONE);
    end

    // State, PC and status flag registers.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            pc_q      <= {PC_W{1'b0}};
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign bus.ProgCtr = pc_q;
    assign bus.Running = running_q;
    assign bus.Done    = done_q;

`ifdef FETCH_INSTR_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Every RUN cycle retires one instruction; saturating, cleared by LOAD.
    always_comb begin
        if (state_d == LOAD) begin
            cnt_d = {CNT_W{1'b0}};
        end else if ((state_q == RUN) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Retired-instruction counter register.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.InstrCount = cnt_q;
`else
    assign bus.InstrCount = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table for the main PC_W=10 instance,
// hand sequences for the instruction counter and a PC_W=4 end-of-ROM stop.
module tb_fetch_unit;

    localparam int PC_W  = 10;
    localparam int CNT_W = 16;

    logic Clk;
    logic rst_n;
    logic rst4_n;

    fetch_unit_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();
    fetch_unit_if #(.PC_W(4),    .CNT_W(CNT_W)) bus4 ();

    fetch_unit #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .Clk     (Clk),
        .Reset_n (rst_n),
        .bus     (bus.slave)
    );

    fetch_unit #(.PC_W(4), .CNT_W(CNT_W)) dut4 (
        .Clk     (Clk),
        .Reset_n (rst4_n),
        .bus     (bus4.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        rst_n;
        logic        start;
        logic [9:0]  addr;
        logic        br;
        logic        tk;
        logic [9:0]  tgt;
        logic        halt;
        logic [9:0]  exp_pc;
        logic        exp_run;
        logic        exp_done;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    logic [CNT_W-1:0] exp_cnt7;

    task automatic add(input logic r, input logic s, input logic [9:0] a,
                       input logic b, input logic t, input logic [9:0] g,
                       input logic h, input logic [9:0] pc,
                       input logic run, input logic dn);
        vec_t v;
        v.rst_n = r; v.start = s; v.addr = a; v.br = b; v.tk = t;
        v.tgt = g; v.halt = h; v.exp_pc = pc; v.exp_run = run; v.exp_done = dn;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [9:0] a, input logic b,
                         input logic t, input logic [9:0] g, input logic h);
        bus.Start = s; bus.StartAddr = a; bus.BranchEn = b;
        bus.Taken = t; bus.Target = g; bus.Halt = h;
    endtask

    initial begin
`ifdef FETCH_INSTR_COUNT_EN
        exp_cnt7 = 16'd7;
`else
        exp_cnt7 = 16'd0;
`endif
        rst_n = 1'b0;
        rst4_n = 1'b0;
        drive(1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 1'b0);
        bus4.Start = 1'b0; bus4.StartAddr = 4'd0; bus4.BranchEn = 1'b0;
        bus4.Taken = 1'b0; bus4.Target = 4'd0; bus4.Halt = 1'b0;

        //   rst  st  addr    br  tk  tgt     hlt  pc       run   done
        add(1'b0,1'b1,10'd5,  1'b0,1'b0,10'd0, 1'b0,10'd0,  1'b0,1'b0); // reset beats Start
        add(1'b1,1'b1,10'd5,  1'b0,1'b0,10'd0, 1'b0,10'd5,  1'b0,1'b0);
        add(1'b1,1'b1,10'd7,  1'b0,1'b0,10'd0, 1'b0,10'd7,  1'b0,1'b0);
        add(1'b1,1'b1,10'd9,  1'b0,1'b0,10'd0, 1'b0,10'd9,  1'b0,1'b0);
        add(1'b1,1'b0,10'd40, 1'b0,1'b0,10'd0, 1'b0,10'd9,  1'b1,1'b0);
        add(1'b1,1'b0,10'd0,  1'b0,1'b0,10'd0, 1'b0,10'd10, 1'b1,1'b0);
        add(1'b1,1'b0,10'd0,  1'b0,1'b0,10'd0, 1'b0,10'd11, 1'b1,1'b0);
        add(1'b1,1'b0,10'd0,  1'b0,1'b0,10'd0, 1'b0,10'd12, 1'b1,1'b0);
        add(1'b1,1'b0,10'd0,  1'b1,1'b1,10'd3, 1'b0,10'd3,  1'b1,1'b0); // taken
        add(1'b1,1'b0,10'd0,  1'b1,1'b1,10'd12,1'b0,10'd12, 1'b1,1'b0);
        add(1'b1,1'b0,10'd0,  1'b1,1'b0,10'd3, 1'b0,10'd13, 1'b1,1'b0); // not taken
        add(1'b1,1'b0,10'd0,  1'b1,1'b1,10'd13,1'b0,10'd13, 1'b1,1'b0); // spin
        add(1'b1,1'b0,10'd0,  1'b0,1'b1,10'd100,1'b0,10'd14,1'b1,1'b0); // Taken w/o BranchEn
        add(1'b1,1'b0,10'd0,  1'b1,1'b1,10'd20,1'b0,10'd20, 1'b1,1'b0);
        add(1'b1,1'b0,10'd0,  1'b1,1'b1,10'd50,1'b1,10'd20, 1'b0,1'b1); // halt beats branch
        add(1'b1,1'b0,10'd0,  1'b1,1'b1,10'd50,1'b0,10'd20, 1'b0,1'b1); // DONE ignores branch
        add(1'b1,1'b1,10'd37, 1'b0,1'b0,10'd0, 1'b0,10'd37, 1'b0,1'b0);
        add(1'b1,1'b0,10'd0,  1'b0,1'b0,10'd0, 1'b0,10'd37, 1'b1,1'b0);
        add(1'b0,1'b1,10'd50, 1'b0,1'b0,10'd0, 1'b0,10'd0,  1'b0,1'b0); // reset mid-RUN
        add(1'b1,1'b0,10'd0,  1'b1,1'b1,10'd40,1'b1,10'd0,  1'b0,1'b0); // IDLE ignores decoder
        add(1'b1,1'b1,10'd1020,1'b0,1'b0,10'd0,1'b0,10'd1020,1'b0,1'b0);
        add(1'b1,1'b0,10'd0,  1'b0,1'b0,10'd0, 1'b0,10'd1020,1'b1,1'b0);
        add(1'b1,1'b0,10'd0,  1'b0,1'b0,10'd0, 1'b0,10'd1021,1'b1,1'b0);
        add(1'b1,1'b0,10'd0,  1'b0,1'b0,10'd0, 1'b0,10'd1022,1'b1,1'b0);
        add(1'b1,1'b0,10'd0,  1'b0,1'b0,10'd0, 1'b0,10'd1023,1'b1,1'b0);
        add(1'b1,1'b0,10'd0,  1'b0,1'b0,10'd0, 1'b0,10'd1023,1'b0,1'b1); // end of ROM
        add(1'b1,1'b1,10'd1023,1'b0,1'b0,10'd0,1'b0,10'd1023,1'b0,1'b0);
        add(1'b1,1'b0,10'd0,  1'b0,1'b0,10'd0, 1'b0,10'd1023,1'b1,1'b0);
        add(1'b1,1'b0,10'd0,  1'b1,1'b1,10'd1023,1'b0,10'd1023,1'b1,1'b0);
        add(1'b1,1'b0,10'd0,  1'b1,1'b1,10'd0, 1'b0,10'd0,  1'b1,1'b0); // branch from last addr
        add(1'b1,1'b0,10'd0,  1'b0,1'b0,10'd0, 1'b0,10'd1,  1'b1,1'b0);
        add(1'b1,1'b1,10'd2,  1'b0,1'b0,10'd0, 1'b0,10'd2,  1'b0,1'b0); // abort/restart

        step();
        for (int i = 0; i < vecs.size(); i++) begin
            rst_n = vecs[i].rst_n;
            drive(vecs[i].start, vecs[i].addr, vecs[i].br, vecs[i].tk,
                  vecs[i].tgt, vecs[i].halt);
            step();
            chk($sformatf("v%0d_pc", i),   32'(bus.ProgCtr), 32'(vecs[i].exp_pc));
            chk($sformatf("v%0d_run", i),  32'(bus.Running), 32'(vecs[i].exp_run));
            chk($sformatf("v%0d_done", i), 32'(bus.Done),    32'(vecs[i].exp_done));
        end

        // Instruction counter: straight-line program from 0, halt at 6.
        rst_n = 1'b0;
        drive(1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 1'b0);
        step();
        chk("cnt_reset", 32'(bus.InstrCount), 32'd0);
        rst_n = 1'b1;
        drive(1'b1, 10'd0, 1'b0, 1'b0, 10'd0, 1'b0);
        step();
        drive(1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 1'b0);
        step();
        chk("cnt_run_pc", 32'(bus.ProgCtr), 32'd0);
        for (int k = 0; k < 6; k++) step();
        chk("cnt_at6_pc", 32'(bus.ProgCtr), 32'd6);
        bus.Halt = 1'b1;
        step();
        bus.Halt = 1'b0;
        chk("cnt_done", 32'(bus.Done), 32'd1);
        chk("cnt_halt_val", 32'(bus.InstrCount), 32'(exp_cnt7));
        step();
        chk("cnt_hold_done", 32'(bus.InstrCount), 32'(exp_cnt7));
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        chk("cnt_restart_clr", 32'(bus.InstrCount), 32'd0);
        chk("cnt_restart_done", 32'(bus.Done), 32'd0);

        // PC_W=4 instance: 14, 15, then DONE holding 15.
        step();
        rst4_n = 1'b1;
        bus4.Start = 1'b1; bus4.StartAddr = 4'd14;
        step();
        chk("w4_load_pc", 32'(bus4.ProgCtr), 32'd14);
        bus4.Start = 1'b0;
        step();
        chk("w4_run14", 32'(bus4.ProgCtr), 32'd14);
        chk("w4_run14_r", 32'(bus4.Running), 32'd1);
        step();
        chk("w4_run15", 32'(bus4.ProgCtr), 32'd15);
        step();
        chk("w4_done_pc", 32'(bus4.ProgCtr), 32'd15);
        chk("w4_done", 32'(bus4.Done), 32'd1);
        chk("w4_done_r", 32'(bus4.Running), 32'd0);
        step();
        chk("w4_hold_pc", 32'(bus4.ProgCtr), 32'd15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
